sequence_checker: RTL and testbench
===================================

# sequence_checker

Consumer side of the game's random-symbol stream. It samples the 2-bit symbol from the random number generator once per round and appends it to a stored sequence. It then plays the whole sequence out to the display, one symbol at a time, and checks the player's button entries against it. The block sits between the random number generator and the button debouncer on one side, and the LED/7-segment display driver on the other.

## Interface
- MAX_LEN, 8: maximum sequence length (rounds to win); range 2..15
- SHOW_CYCLES, 4: cycles each symbol is presented with disp_valid high; ≥1
- GAP_CYCLES, 2: blank cycles after each presented symbol; ≥1
- clk  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-low; reset==0 at a posedge initializes the block
- rand_sym  input  2  current generator symbol, always in 0..2; sampled only in CAPTURE
- start  input  1  one-cycle pulse; begins a new game from IDLE, WIN or LOSE
- btn_valid  input  1  one-cycle pulse, player pressed a button
- btn_sym  input  2  player symbol, qualified by btn_valid
- disp_sym  output  2  symbol under presentation; 0 when disp_valid is low
- disp_valid  output  1  high while a symbol is presented
- await_input  output  1  high in WAIT_IN
- match  output  1  one-cycle pulse: round completed correctly
- mismatch  output  1  one-cycle pulse: wrong entry
- level  output  4  current sequence length, 0..MAX_LEN
- done  output  1  high in WIN or LOSE
- win  output  1  high in WIN only

## Operation
- States: IDLE, CAPTURE, SHOW, GAP, WAIT_IN, WIN, LOSE.
- Reset: state=IDLE, level=0, idx=0, cycle counter=0, all outputs 0. The memory contents are not cleared.
- IDLE, WIN, LOSE + start: level←0, go to CAPTURE. start is ignored in all other states.
- CAPTURE, one cycle: mem[level]←rand_sym, level←level+1, idx←0, counter←0, go to SHOW.
- SHOW: disp_valid=1, disp_sym=mem[idx] for SHOW_CYCLES cycles, then go to GAP.
- GAP: outputs blank for GAP_CYCLES cycles.
  - At the end of GAP, if idx==level-1: idx←0, go to WAIT_IN.
  - Otherwise idx←idx+1 and go back to SHOW.
- WAIT_IN on btn_valid:
  - btn_sym != mem[idx], including btn_sym==3: pulse mismatch, go to LOSE.
  - Equal and idx<level-1: idx←idx+1.
  - Equal and idx==level-1: pulse match. If level==MAX_LEN go to WIN, else go to CAPTURE.
- btn_valid is ignored outside WAIT_IN, and there is no input timeout.
- The counter is log2-sized to max(SHOW_CYCLES, GAP_CYCLES). level and idx never exceed MAX_LEN, so they never wrap.

## Timing
- All outputs are registered, driven directly from state or from flops.
- start sampled at edge N: CAPTURE occupies cycle N+1, and rand_sym is sampled at edge N+1.
  - level shows the new value from cycle N+2.
  - disp_valid is high from cycle N+2 through N+1+SHOW_CYCLES.
- A round of length L spends L×(SHOW_CYCLES+GAP_CYCLES) cycles in SHOW/GAP.
- btn_valid sampled at edge M:
  - match or mismatch is high in cycle M+1 only.
  - The state change (CAPTURE, WIN or LOSE) is also visible in cycle M+1.
- btn_valid together with start in WAIT_IN: start is ignored and btn_valid is processed.
- Reset mid-game: takes effect at the next posedge regardless of state, and any pending pulse is dropped.

## Structure
- Shared package/header game_pkg holds:
  - the state encodings
  - SYM_W=2
  - SYM_INVALID=2'b11
  - default parameter constants, shared with the generator and the display driver
- Sub-module seq_mem: MAX_LEN×SYM_W register file with one synchronous write port and one combinational read port, indexed by level (write) or idx (read).
- The FSM and counters stay in sequence_checker.

## Test plan
- Basic round: MAX_LEN=8, SHOW=4, GAP=2, rand_sym=2, pulse start.
  - level=1.
  - disp_sym=2 with disp_valid high for exactly 4 cycles, then 2 blank cycles.
  - await_input goes high; btn_sym=2 → match for 1 cycle, level becomes 2 after the next CAPTURE.
- Multi-round playback: rand_sym sequence 0,1,2 across rounds.
  - Round 3 presents 0,1,2 in order, with a gap after each.
  - Entering 0,1,2 → match.
- Error: in round 2 with stored sequence 1,0, enter 1 then 2 → mismatch pulse, done=1, win=0, state LOSE. Then start → level=1.
- Invalid and stray input:
  - btn_sym=3 in WAIT_IN → mismatch.
  - btn_valid during SHOW or GAP → no pulse, idx unchanged.
  - start during SHOW → ignored.
- Win: MAX_LEN=2, complete 2 rounds correctly → match pulse, then win=1 and done=1. Start restarts at level=1.
- Reset mid-operation: assert reset=0 for 1 cycle during SHOW of round 3 → next cycle IDLE, level=0, all outputs 0. Release reset and pulse start → normal round 1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the memory game: symbol encoding, FSM states and
// default timing constants used by the generator, checker and display driver.
package game_pkg;

  localparam int unsigned SYM_W = 2;
  localparam logic [SYM_W-1:0] SYM_INVALID = 2'b11;

  // level and idx are 4 bits wide so MAX_LEN up to 15 never wraps.
  localparam int unsigned LVL_W = 4;

  localparam int unsigned DEF_MAX_LEN     = 8;
  localparam int unsigned DEF_SHOW_CYCLES = 4;
  localparam int unsigned DEF_GAP_CYCLES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SHOW,
    ST_GAP,
    ST_WAIT_IN,
    ST_WIN,
    ST_LOSE
  } state_t;

  // Width able to hold max(a, b) - 1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/seq_mem.sv
// Sequence storage: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module seq_mem
  import game_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_MAX_LEN
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LVL_W-1:0] waddr,
  input  logic [SYM_W-1:0] wdata,
  input  logic [LVL_W-1:0] raddr,
  output logic [SYM_W-1:0] rdata
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  logic [SYM_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wa;
  logic [AW-1:0]    ra;

  assign wa = waddr[AW-1:0];
  assign ra = raddr[AW-1:0];

  always_ff @(posedge clk) begin
    if (we && (waddr < DEPTH_L)) begin
      mem[wa] <= wdata;
    end
  end

  assign rdata = (raddr < DEPTH_L) ? mem[ra] : '0;

endmodule

// File: rtl/sequence_checker.sv
// Stores one random symbol per round, plays the sequence to the display and
// checks the player's button entries against it.
module sequence_checker
  import game_pkg::*;
#(
  parameter int unsigned MAX_LEN     = DEF_MAX_LEN,
  parameter int unsigned SHOW_CYCLES = DEF_SHOW_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SYM_W-1:0] rand_sym,
  input  logic             start,
  input  logic             btn_valid,
  input  logic [SYM_W-1:0] btn_sym,
  output logic [SYM_W-1:0] disp_sym,
  output logic             disp_valid,
  output logic             await_input,
  output logic             match,
  output logic             mismatch,
  output logic [LVL_W-1:0] level,
  output logic             done,
  output logic             win
);

  localparam int unsigned CNT_W = cnt_width(SHOW_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [LVL_W-1:0] MAX_LVL   = LVL_W'(MAX_LEN);

  state_t           state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, match_d;
  logic             mismatch_q, mismatch_d;
  logic             mem_we;
  logic [SYM_W-1:0] rd_sym;
  logic             last_idx;

  seq_mem #(
    .DEPTH(MAX_LEN)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(level_q),
    .wdata(rand_sym),
    .raddr(idx_q),
    .rdata(rd_sym)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      level_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign last_idx = (idx_q == (level_q - LVL_W'(1)));

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          level_d = '0;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        mem_we  = 1'b1;
        level_d = level_q + LVL_W'(1);
        idx_d   = '0;
        cnt_d   = '0;
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (last_idx) begin
            idx_d   = '0;
            state_d = ST_WAIT_IN;
          end else begin
            idx_d   = idx_q + LVL_W'(1);
            state_d = ST_SHOW;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_IN: begin
        if (btn_valid) begin
          // SYM_INVALID is rejected even if a stale memory word happens to hold 3.
          if ((btn_sym == SYM_INVALID) || (btn_sym != rd_sym)) begin
            mismatch_d = 1'b1;
            state_d    = ST_LOSE;
          end else if (!last_idx) begin
            idx_d = idx_q + LVL_W'(1);
          end else begin
            match_d = 1'b1;
            state_d = (level_q == MAX_LVL) ? ST_WIN : ST_CAPTURE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign disp_valid  = (state_q == ST_SHOW);
  assign disp_sym    = disp_valid ? rd_sym : '0;
  assign await_input = (state_q == ST_WAIT_IN);
  assign done        = (state_q == ST_WIN) || (state_q == ST_LOSE);
  assign win         = (state_q == ST_WIN);
  assign match       = match_q;
  assign mismatch    = mismatch_q;
  assign level       = level_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker: one MAX_LEN=8 instance and one
// MAX_LEN=2 instance for the win path, selected by sel.
module tb_sequence_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] rand_sym = 2'd0;
  logic       start = 1'b0;
  logic       btn_valid = 1'b0;
  logic [1:0] btn_sym = 2'd0;
  logic       sel = 1'b0;

  logic [1:0] a_disp_sym, b_disp_sym;
  logic       a_disp_valid, b_disp_valid;
  logic       a_await, b_await;
  logic       a_match, b_match;
  logic       a_mismatch, b_mismatch;
  logic [3:0] a_level, b_level;
  logic       a_done, b_done;
  logic       a_win, b_win;

  logic       a_start, b_start, a_btn_valid, b_btn_valid;
  assign a_start     = start & ~sel;
  assign b_start     = start & sel;
  assign a_btn_valid = btn_valid & ~sel;
  assign b_btn_valid = btn_valid & sel;

  sequence_checker #(
    .MAX_LEN(8),
    .SHOW_CYCLES(4),
    .GAP_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rand_sym   (rand_sym),
    .start      (a_start),
    .btn_valid  (a_btn_valid),
    .btn_sym    (btn_sym),
    .disp_sym   (a_disp_sym),
    .disp_valid (a_disp_valid),
    .await_input(a_await),
    .match      (a_match),
    .mismatch   (a_mismatch),
    .level      (a_level),
    .done       (a_done),
    .win        (a_win)
  );

  sequence_checker #(
    .MAX_LEN(2),
    .SHOW_CYCLES(4),
    .GAP_CYCLES(2)
  ) dut2 (
    .clk        (clk),
    .reset      (reset),
    .rand_sym   (rand_sym),
    .start      (b_start),
    .btn_valid  (b_btn_valid),
    .btn_sym    (btn_sym),
    .disp_sym   (b_disp_sym),
    .disp_valid (b_disp_valid),
    .await_input(b_await),
    .match      (b_match),
    .mismatch   (b_mismatch),
    .level      (b_level),
    .done       (b_done),
    .win        (b_win)
  );

  logic [1:0] disp_sym;
  logic       disp_valid, await_input, match, mismatch, done, win;
  logic [3:0] level;
  assign disp_sym    = sel ? b_disp_sym   : a_disp_sym;
  assign disp_valid  = sel ? b_disp_valid : a_disp_valid;
  assign await_input = sel ? b_await      : a_await;
  assign match       = sel ? b_match      : a_match;
  assign mismatch    = sel ? b_mismatch   : a_mismatch;
  assign level       = sel ? b_level      : a_level;
  assign done        = sel ? b_done       : a_done;
  assign win         = sel ? b_win        : a_win;

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // start pulse; ends in the first SHOW cycle
  task automatic begin_game(input logic [1:0] r);
    rand_sym = r;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cap_level", level, 0);
    chk("cap_valid", disp_valid, 0);
    chk("cap_done", done, 0);
    tick();
  endtask

  // seq holds symbol i at bits [2i+1:2i]; ends in the first WAIT_IN cycle
  task automatic show_seq(input int len, input logic [7:0] seq, input int lvl, input bit stray);
    logic [7:0] sh;
    for (int i = 0; i < len; i++) begin
      sh = seq >> (2 * i);
      for (int c = 0; c < 4; c++) begin
        chk("show_valid", disp_valid, 1);
        chk("show_sym", disp_sym, sh[1:0]);
        chk("show_level", level, lvl[7:0]);
        chk("show_pulse", {match, mismatch, await_input}, 0);
        btn_valid = stray;
        btn_sym   = 2'd0;
        start     = stray;
        tick();
      end
      for (int c = 0; c < 2; c++) begin
        chk("gap_valid", disp_valid, 0);
        chk("gap_sym", disp_sym, 0);
        chk("gap_pulse", {match, mismatch, await_input}, 0);
        tick();
      end
    end
    btn_valid = 1'b0;
    start     = 1'b0;
    chk("await", await_input, 1);
  endtask

  // one button press; ends in cycle M+1
  task automatic press(input logic [1:0] b, input bit with_start);
    btn_valid = 1'b1;
    btn_sym   = b;
    start     = with_start;
    tick();
    btn_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic expect_match(input int lvl);
    chk("match", match, 1);
    chk("match_mm", mismatch, 0);
    chk("match_await", await_input, 0);
    chk("match_level", level, lvl[7:0]);
  endtask

  task automatic expect_progress(input int lvl);
    chk("prog_pulse", {match, mismatch}, 0);
    chk("prog_await", await_input, 1);
    chk("prog_level", level, lvl[7:0]);
  endtask

  initial begin
    reset = 1'b0;
    tick();
    tick();
    chk("rst_level", level, 0);
    chk("rst_disp", {disp_valid, disp_sym}, 0);
    chk("rst_flags", {await_input, match, mismatch, done, win}, 0);
    chk("rst_level2", b_level, 0);
    reset = 1'b1;
    tick();
    chk("idle_hold", {disp_valid, await_input, done}, 0);

    // basic round
    begin_game(2'd2);
    show_seq(1, 8'h02, 1, 1'b0);
    press(2'd2, 1'b0);
    expect_match(1);
    rand_sym = 2'd1;
    tick();
    chk("match_once", match, 0);

    // round 2 (2,1) with stray start/btn during playback, then wrong entry
    show_seq(2, 8'h06, 2, 1'b1);
    press(2'd2, 1'b1);
    expect_progress(2);
    press(2'd0, 1'b0);
    chk("lose_mm", mismatch, 1);
    chk("lose_match", match, 0);
    chk("lose_done", done, 1);
    chk("lose_win", win, 0);
    chk("lose_await", await_input, 0);
    tick();
    chk("lose_mm_once", mismatch, 0);
    chk("lose_hold", {done, win}, 2'b10);

    // multi-round playback 0,1,2
    begin_game(2'd0);
    show_seq(1, 8'h00, 1, 1'b0);
    press(2'd0, 1'b0);
    expect_match(1);
    rand_sym = 2'd1;
    tick();
    show_seq(2, 8'h04, 2, 1'b0);
    press(2'd0, 1'b0);
    expect_progress(2);
    press(2'd1, 1'b0);
    expect_match(2);
    rand_sym = 2'd2;
    tick();
    show_seq(3, 8'h24, 3, 1'b0);
    press(2'd0, 1'b0);
    expect_progress(3);
    press(2'd1, 1'b0);
    expect_progress(3);
    press(2'd2, 1'b0);
    expect_match(3);
    rand_sym = 2'd0;
    tick();

    // reset during playback of round 4
    chk("r4_level", level, 4);
    chk("r4_sym", {disp_valid, disp_sym}, 3'b100);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_disp", {disp_valid, disp_sym}, 0);
    chk("mid_rst_flags", {await_input, match, mismatch, done, win}, 0);
    tick();
    chk("post_rst_idle", {level, disp_valid, await_input}, 0);

    // fresh round after reset, invalid symbol entry
    begin_game(2'd1);
    show_seq(1, 8'h01, 1, 1'b0);
    press(2'd3, 1'b0);
    chk("inv_mm", mismatch, 1);
    chk("inv_match", match, 0);
    chk("inv_done", {done, win}, 2'b10);
    tick();

    // MAX_LEN=2 instance: win path and restart
    sel = 1'b1;
    begin_game(2'd1);
    show_seq(1, 8'h01, 1, 1'b0);
    press(2'd1, 1'b0);
    expect_match(1);
    chk("w_r1_done", done, 0);
    rand_sym = 2'd2;
    tick();
    show_seq(2, 8'h09, 2, 1'b0);
    press(2'd1, 1'b0);
    expect_progress(2);
    press(2'd2, 1'b0);
    expect_match(2);
    chk("win_flag", win, 1);
    chk("win_done", done, 1);
    tick();
    chk("win_match_once", match, 0);
    chk("win_hold", {done, win}, 2'b11);
    begin_game(2'd0);
    chk("restart_win", win, 0);
    show_seq(1, 8'h00, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
